bioz_sweep_sequencer: RTL and testbench

Synthesizable, parametrised BioZ measurement sequencer that drives the signal-generator frequency select, the electrode-array row/column mux and the ADC conversion strobe from one clock. For each electrode pair it sweeps Fsel from FSEL_START down to FSEL_END. At each frequency it discards SETTLE_CONV conversions, then tags CONV_PER_STEP valid conversions. It sits between the top-level control register block and the AFE/ADC, and adds start/abort/loop control and a completion handshake.

---
 rtl/bioz_pkg.sv | 20 ++
 rtl/bioz_adc_slot_timer.sv | 74 +++++++
 rtl/bioz_sweep_sequencer.sv | 177 +++++++++++++++++
 tb/tb_bioz_sweep_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bioz_pkg.sv
// Shared types and default constants for the BioZ sweep sequencer.
// Also holds a width helper that never returns less than one bit.
package bioz_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        FINISH  = 2'd3
    } bioz_state_e;

    localparam int                    BIOZ_FSEL_W     = 4;
    localparam int                    BIOZ_ADC_PERIOD = 15;
    localparam logic [BIOZ_FSEL_W-1:0] BIOZ_FSEL_START = 4'b1100;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/bioz_adc_slot_timer.sv
// Conversion-slot timer: owns the period counter and the slot counter within a phase.
// It also registers the ADC strobe, the kept-sample pulse and the sample index.
module bioz_adc_slot_timer
    import bioz_pkg::*;
#(
    parameter int ADC_PERIOD = BIOZ_ADC_PERIOD,
    parameter int SLOT_W     = 5,
    parameter int IDX_W      = 4
) (
    input  logic              clk_ADC,
    input  logic              Reset,
    input  logic              run_nxt,
    input  logic              meas_nxt,
    input  logic              restart,
    input  logic [SLOT_W-1:0] phase_len,
    output logic              end_slot,
    output logic              end_phase,
    output logic              adc_start,
    output logic              sample_valid,
    output logic [IDX_W-1:0]  sample_idx
);

    localparam int               PC_W    = clog2_min1(ADC_PERIOD);
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(ADC_PERIOD - 1);
    localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
    localparam logic [SLOT_W:0]  SLOT_ONE_X = (SLOT_W+1)'(1);

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_nxt;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_nxt;
    logic              strobe_nxt;
    logic              keep_nxt;

    // end_phase marks the final slot of the phase; the top combines it with end_slot.
    assign end_slot  = (pc == PC_LAST);
    assign end_phase = (({1'b0, slot} + SLOT_ONE_X) == {1'b0, phase_len});

    always_comb begin
        pc_nxt   = '0;
        slot_nxt = '0;
        if (run_nxt && !restart) begin
            if (end_slot) begin
                pc_nxt   = '0;
                slot_nxt = slot + SLOT_W'(1);
            end else begin
                pc_nxt   = pc + PC_ONE;
                slot_nxt = slot;
            end
        end
    end

    assign strobe_nxt = run_nxt && (pc_nxt == PC_ONE);
    assign keep_nxt   = run_nxt && meas_nxt && (pc_nxt == PC_LAST);

    always_ff @(posedge clk_ADC) begin
        if (Reset) begin
            pc           <= '0;
            slot         <= '0;
            adc_start    <= 1'b0;
            sample_valid <= 1'b0;
            sample_idx   <= '0;
        end else begin
            pc           <= pc_nxt;
            slot         <= slot_nxt;
            adc_start    <= strobe_nxt;
            sample_valid <= keep_nxt;
            if (keep_nxt) begin
                sample_idx <= slot_nxt[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bioz_sweep_sequencer.sv
// BioZ sweep sequencer: steps Fsel from FSEL_START down to FSEL_END for every electrode pair,
// discarding settle conversions and tagging kept conversions, with start/abort/loop control.
module bioz_sweep_sequencer
    import bioz_pkg::*;
#(
    parameter int FSEL_W        = BIOZ_FSEL_W,
    parameter int FSEL_START    = int'(BIOZ_FSEL_START),
    parameter int FSEL_END      = 0,
    parameter int ROW_W         = 2,
    parameter int COL_W         = 2,
    parameter int N_ROWS        = 4,
    parameter int N_COLS        = 4,
    parameter int ADC_PERIOD    = BIOZ_ADC_PERIOD,
    parameter int CONV_PER_STEP = 16,
    parameter int SETTLE_CONV   = 2,
    parameter int IDX_W         = clog2_min1(CONV_PER_STEP)
) (
    input  logic              clk_ADC,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Loop,
    output logic              Busy,
    output logic              Done,
    output logic [FSEL_W-1:0] Fsel,
    output logic [ROW_W-1:0]  Row,
    output logic [COL_W-1:0]  Col,
    output logic              Clk_En,
    output logic              ADC_En,
    output logic              ADC_Start,
    output logic              Sample_Valid,
    output logic [IDX_W-1:0]  Sample_Idx
);

    localparam int SLOT_MAX = (CONV_PER_STEP > SETTLE_CONV) ? CONV_PER_STEP : SETTLE_CONV;
    localparam int SLOT_W   = clog2_min1(SLOT_MAX + 1);

    localparam logic [FSEL_W-1:0] F_START  = FSEL_W'(FSEL_START);
    localparam logic [FSEL_W-1:0] F_END    = FSEL_W'(FSEL_END);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(N_ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(N_COLS - 1);
    localparam logic [SLOT_W-1:0] LEN_MEAS = SLOT_W'(CONV_PER_STEP);
    localparam logic [SLOT_W-1:0] LEN_SETL = SLOT_W'(SETTLE_CONV);

    // With no settle conversions every step enters MEASURE directly.
    localparam bioz_state_e FIRST_PHASE = (SETTLE_CONV == 0) ? MEASURE : SETTLE;

    bioz_state_e       state;
    bioz_state_e       state_nxt;
    logic [FSEL_W-1:0] fsel_q;
    logic [FSEL_W-1:0] fsel_nxt;
    logic [ROW_W-1:0]  row_q;
    logic [ROW_W-1:0]  row_nxt;
    logic [COL_W-1:0]  col_q;
    logic [COL_W-1:0]  col_nxt;
    logic              busy_q;
    logic              done_q;
    logic              restart;
    logic              run_nxt;
    logic              meas_nxt;
    logic              end_slot;
    logic              end_phase;
    logic              phase_done;
    logic              last_electrode;
    logic [SLOT_W-1:0] phase_len;

    assign phase_len      = (state == MEASURE) ? LEN_MEAS : LEN_SETL;
    assign phase_done     = end_slot && end_phase;
    assign last_electrode = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        state_nxt = state;
        fsel_nxt  = fsel_q;
        row_nxt   = row_q;
        col_nxt   = col_q;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (Start && !Abort) begin
                    state_nxt = FIRST_PHASE;
                    fsel_nxt  = F_START;
                    row_nxt   = '0;
                    col_nxt   = '0;
                    restart   = 1'b1;
                end
            end
            SETTLE: begin
                if (Abort) begin
                    state_nxt = IDLE;
                end else if (phase_done) begin
                    state_nxt = MEASURE;
                    restart   = 1'b1;
                end
            end
            MEASURE: begin
                if (Abort) begin
                    state_nxt = IDLE;
                end else if (phase_done) begin
                    state_nxt = FIRST_PHASE;
                    restart   = 1'b1;
                    if (fsel_q != F_END) begin
                        fsel_nxt = fsel_q - FSEL_W'(1);
                    end else if (!last_electrode) begin
                        fsel_nxt = F_START;
                        if (col_q == COL_LAST) begin
                            col_nxt = '0;
                            row_nxt = row_q + ROW_W'(1);
                        end else begin
                            col_nxt = col_q + COL_W'(1);
                        end
                    end else if (Loop) begin
                        fsel_nxt = F_START;
                        row_nxt  = '0;
                        col_nxt  = '0;
                    end else begin
                        state_nxt = FINISH;
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign run_nxt  = (state_nxt == SETTLE) || (state_nxt == MEASURE);
    assign meas_nxt = (state_nxt == MEASURE);

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk_ADC) begin
        if (Reset) begin
            state  <= IDLE;
            fsel_q <= F_START;
            row_q  <= '0;
            col_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            fsel_q <= fsel_nxt;
            row_q  <= row_nxt;
            col_q  <= col_nxt;
            busy_q <= run_nxt;
            done_q <= (state_nxt == FINISH);
        end
    end

    bioz_adc_slot_timer #(
        .ADC_PERIOD (ADC_PERIOD),
        .SLOT_W     (SLOT_W),
        .IDX_W      (IDX_W)
    ) u_slot_timer (
        .clk_ADC      (clk_ADC),
        .Reset        (Reset),
        .run_nxt      (run_nxt),
        .meas_nxt     (meas_nxt),
        .restart      (restart),
        .phase_len    (phase_len),
        .end_slot     (end_slot),
        .end_phase    (end_phase),
        .adc_start    (ADC_Start),
        .sample_valid (Sample_Valid),
        .sample_idx   (Sample_Idx)
    );

    assign Busy   = busy_q;
    assign Clk_En = busy_q;
    assign ADC_En = busy_q;
    assign Done   = done_q;
    assign Fsel   = fsel_q;
    assign Row    = row_q;
    assign Col    = col_q;

endmodule

// File: tb/tb_bioz_sweep_sequencer.sv
// Bench for bioz_sweep_sequencer: an arithmetic scan-position model checked every cycle,
// directed scenarios with literal expectations, and a randomized control phase.
module tb_bioz_sweep_sequencer;

    localparam int P    = 4;
    localparam int S    = 1;
    localparam int C    = 2;
    localparam int FS   = 2;
    localparam int FE   = 1;
    localparam int NR   = 1;
    localparam int NC   = 2;
    localparam int NF   = FS - FE + 1;
    localparam int STEP = (S + C) * P;
    localparam int SCAN = STEP * NF * NR * NC;

    logic       clk_ADC = 1'b0;
    logic       Reset, Start, Abort, Loop;
    logic       Busy, Done, Clk_En, ADC_En, ADC_Start, Sample_Valid;
    logic [3:0] Fsel;
    logic [1:0] Row, Col;
    logic [0:0] Sample_Idx;

    logic       Start5;
    logic       Busy5, Done5, Clk_En5, ADC_En5, ADC_Start5, Sample_Valid5;
    logic [3:0] Fsel5;
    logic [1:0] Row5, Col5;
    logic [0:0] Sample_Idx5;

    bioz_sweep_sequencer #(
        .FSEL_W(4), .FSEL_START(FS), .FSEL_END(FE), .ROW_W(2), .COL_W(2),
        .N_ROWS(NR), .N_COLS(NC), .ADC_PERIOD(P), .CONV_PER_STEP(C), .SETTLE_CONV(S), .IDX_W(1)
    ) dut (
        .clk_ADC(clk_ADC), .Reset(Reset), .Start(Start), .Abort(Abort), .Loop(Loop),
        .Busy(Busy), .Done(Done), .Fsel(Fsel), .Row(Row), .Col(Col), .Clk_En(Clk_En),
        .ADC_En(ADC_En), .ADC_Start(ADC_Start), .Sample_Valid(Sample_Valid), .Sample_Idx(Sample_Idx)
    );

    bioz_sweep_sequencer #(
        .FSEL_W(4), .FSEL_START(5), .FSEL_END(5), .ROW_W(2), .COL_W(2),
        .N_ROWS(1), .N_COLS(1), .ADC_PERIOD(3), .CONV_PER_STEP(1), .SETTLE_CONV(0), .IDX_W(1)
    ) dut5 (
        .clk_ADC(clk_ADC), .Reset(Reset), .Start(Start5), .Abort(1'b0), .Loop(1'b0),
        .Busy(Busy5), .Done(Done5), .Fsel(Fsel5), .Row(Row5), .Col(Col5), .Clk_En(Clk_En5),
        .ADC_En(ADC_En5), .ADC_Start(ADC_Start5), .Sample_Valid(Sample_Valid5), .Sample_Idx(Sample_Idx5)
    );

    always #5 clk_ADC = ~clk_ADC;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Scan position model: t counts cycles since the first busy cycle of the current scan.
    bit m_run = 1'b0;
    bit m_fin = 1'b0;
    int m_t   = 0;
    int si, w, slot, pc, el;
    int e_busy = 0, e_done = 0, e_fsel = FS, e_row = 0, e_col = 0;
    int e_adc = 0, e_valid = 0, e_idx = 0;

    always @(posedge clk_ADC) begin
        if (Reset) begin
            m_run = 1'b0; m_fin = 1'b0;
            e_fsel = FS; e_row = 0; e_col = 0;
        end else if (m_run) begin
            if (Abort) m_run = 1'b0;
            else begin
                m_t++;
                if (m_t == SCAN) begin
                    if (Loop) m_t = 0;
                    else begin m_run = 1'b0; m_fin = 1'b1; end
                end
            end
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (Start && !Abort) begin
            m_run = 1'b1; m_t = 0;
        end
        e_busy = m_run; e_done = m_fin; e_adc = 0; e_valid = 0;
        if (m_run) begin
            si = m_t / STEP; w = m_t % STEP; slot = w / P; pc = w % P;
            e_fsel = FS - (si % NF);
            el = si / NF; e_row = el / NC; e_col = el % NC;
            e_adc = (pc == 1);
            e_valid = (slot >= S) && (pc == P - 1);
            e_idx = slot - S;
        end
    end

    always @(negedge clk_ADC) begin
        if (chk_en) begin
            check("busy", Busy, e_busy);
            check("done", Done, e_done);
            check("fsel", Fsel, e_fsel);
            check("row", Row, e_row);
            check("col", Col, e_col);
            check("clk_en", Clk_En, e_busy);
            check("adc_en", ADC_En, e_busy);
            check("adc_start", ADC_Start, e_adc);
            check("sample_valid", Sample_Valid, e_valid);
            if (e_valid != 0) check("sample_idx", Sample_Idx, e_idx);
        end
    end

    task automatic tick();
        @(posedge clk_ADC);
        #1;
    endtask

    int n_adc, n_val, n_done, n_late;

    initial begin
        Reset = 1'b1; Start = 1'b0; Abort = 1'b0; Loop = 1'b0; Start5 = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        Reset = 1'b0;
        tick();
        check("rst_busy", Busy, 0);
        check("rst_fsel", Fsel, 2);
        check("rst_col", Col, 0);
        check("rst_idx", Sample_Idx, 0);
        check("rst_adc", ADC_Start, 0);

        // Start and Abort together in IDLE
        Start = 1'b1; Abort = 1'b1; tick(); Start = 1'b0; Abort = 1'b0;
        check("start_abort_idle", Busy, 0);
        tick();

        // Basic sweep, with Start pulses while busy
        n_adc = 0; n_val = 0; n_done = 0;
        Start = 1'b1; tick(); Start = 1'b0;
        for (int c = 1; c <= 52; c++) begin
            if (ADC_Start) n_adc++;
            if (Sample_Valid) n_val++;
            if (Done) n_done++;
            if (c == 1)  check("t1_busy_c1", Busy, 1);
            if (c == 2)  check("t1_adc_c2", ADC_Start, 1);
            if (c == 8)  begin check("t1_valid_c8", Sample_Valid, 1); check("t1_idx_c8", Sample_Idx, 0); end
            if (c == 12) begin check("t1_valid_c12", Sample_Valid, 1); check("t1_idx_c12", Sample_Idx, 1); end
            if (c == 13) check("t1_fsel_c13", Fsel, 1);
            if (c == 25) begin check("t1_col_c25", Col, 1); check("t1_fsel_c25", Fsel, 2); end
            if (c == 48) check("t1_busy_c48", Busy, 1);
            if (c == 49) begin check("t1_done_c49", Done, 1); check("t1_busy_c49", Busy, 0); end
            Start = (c == 10) || (c == 30);
            tick();
        end
        Start = 1'b0;
        check("t1_n_valid", n_val, 8);
        check("t1_n_adc", n_adc, 12);
        check("t1_n_done", n_done, 1);

        // Abort mid-scan
        n_late = 0; n_done = 0;
        Start = 1'b1; tick(); Start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 21) begin
                check("t2_busy_c21", Busy, 0);
                check("t2_fsel_c21", Fsel, 1);
                check("t2_col_c21", Col, 0);
            end
            if (c > 20 && ADC_Start) n_late++;
            if (c > 20 && Done) n_done++;
            Abort = (c == 20);
            tick();
        end
        Abort = 1'b0;
        check("t2_late_adc", n_late, 0);
        check("t2_no_done", n_done, 0);

        // Loop restart at end of scan
        Loop = 1'b1; Start = 1'b1; tick(); Start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 49) begin
                check("t3_done_c49", Done, 0);
                check("t3_fsel_c49", Fsel, 2);
                check("t3_col_c49", Col, 0);
                check("t3_busy_c49", Busy, 1);
            end
            if (c == 56) check("t3_valid_c56", Sample_Valid, 1);
            tick();
        end
        Abort = 1'b1; tick(); Abort = 1'b0; Loop = 1'b0; tick();

        // Reset mid-scan, then restart
        Start = 1'b1; tick(); Start = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            if (c == 31) begin
                check("t4_busy_c31", Busy, 0);
                check("t4_fsel_c31", Fsel, 2);
                check("t4_col_c31", Col, 0);
                check("t4_adc_c31", ADC_Start, 0);
            end
            Reset = (c == 30);
            tick();
        end
        Reset = 1'b0;
        Start = 1'b1; tick(); Start = 1'b0;
        check("t4_restart_busy", Busy, 1);
        check("t4_restart_fsel", Fsel, 2);
        check("t4_restart_col", Col, 0);
        for (int c = 0; c < 60; c++) tick();

        // No settle, single conversion, single frequency and electrode
        Start5 = 1'b1; tick(); Start5 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check("t5_adc", ADC_Start5, (c == 2));
            check("t5_valid", Sample_Valid5, (c == 3));
            check("t5_done", Done5, (c == 4));
            check("t5_busy", Busy5, (c <= 3));
            check("t5_en", {30'd0, Clk_En5, ADC_En5}, (c <= 3) ? 3 : 0);
            if (c == 1) check("t5_fsel_rowcol", {Fsel5, Row5, Col5}, {4'd5, 2'd0, 2'd0});
            if (c == 3) check("t5_idx", Sample_Idx5, 0);
            tick();
        end

        // Randomized control
        for (int i = 0; i < 3000; i++) begin
            Start = ($urandom % 6) == 0;
            Abort = ($urandom % 80) == 0;
            Loop  = ($urandom % 3) == 0;
            Reset = ($urandom % 700) == 0;
            tick();
        end
        Start = 1'b0; Abort = 1'b0; Loop = 1'b0; Reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
